// File: rtl/imem_responder_if.sv
// Fetch and loader signal bundle for imem_responder.
// The slave modport is the responder; the master modport is the CPU fetch stage plus loader.
interface imem_responder_if;
  logic [31:0] imem_addr_i;
  logic        imem_en_i;
  logic [31:0] imem_rdata_o;
  logic        imem_fault_o;
  logic        load_valid_i;
  logic [7:0]  load_data_i;
  logic        load_last_i;
  logic        load_ready_o;
  logic        reload_i;
  logic        busy_o;
  logic        load_done_o;

  modport slave (
    input  imem_addr_i, imem_en_i, load_valid_i, load_data_i, load_last_i, reload_i,
    output imem_rdata_o, imem_fault_o, load_ready_o, busy_o, load_done_o
  );

  modport master (
    output imem_addr_i, imem_en_i, load_valid_i, load_data_i, load_last_i, reload_i,
    input  imem_rdata_o, imem_fault_o, load_ready_o, busy_o, load_done_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a byte-stream boot loader: LOAD fills words little-endian,
// READY serves 1-cycle-latency fetches with misalignment / range fault reporting.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          BOOT_LOAD   = 1'b1,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic           clk_i,
  input  logic           rst_i,
  imem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {ST_LOAD, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] word_ptr_q, word_ptr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic          load_done_q, load_done_d;
  logic          use_ram_q, use_ram_d;
  logic          fault_q, fault_d;
  logic [31:0]   ram_rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   fetch_idx;
  logic          fetch_fault;
  logic          accept;
  logic          word_full;
  logic          last_slot;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          end_load;

  // Modular subtraction lets addresses below BASE_ADDR wrap to huge indices and fault.
  assign fetch_idx   = (bus.imem_addr_i - BASE_ADDR) >> 2;
  assign fetch_fault = (bus.imem_addr_i[1:0] != 2'b00) || (fetch_idx >= DEPTH_WORDS);

  assign accept    = bus.load_valid_i && (state_q == ST_LOAD);
  assign word_full = (byte_cnt_q == 2'd3);
  assign last_slot = (word_ptr_q == AW'(DEPTH_WORDS - 1));
  assign wr_en     = accept && !rst_i && (word_full || bus.load_last_i);
  assign wr_data   = {8'h00, asm_q} | (32'(bus.load_data_i) << {byte_cnt_q, 3'b000});
  assign end_load  = accept && (bus.load_last_i || (word_full && last_slot));

  always_comb begin
    state_d     = state_q;
    word_ptr_d  = word_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    load_done_d = 1'b0;
    use_ram_d   = use_ram_q;
    fault_d     = fault_q;

    if (bus.imem_en_i) begin
      use_ram_d = (state_q == ST_READY) && !fetch_fault;
      fault_d   = (state_q == ST_READY) && fetch_fault;
    end

    if (state_q == ST_LOAD) begin
      if (end_load) begin
        state_d     = ST_READY;
        word_ptr_d  = '0;
        byte_cnt_d  = 2'd0;
        asm_d       = '0;
        load_done_d = 1'b1;
      end else if (wr_en) begin
        word_ptr_d = word_ptr_q + 1'b1;
        byte_cnt_d = 2'd0;
        asm_d      = '0;
      end else if (accept) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = asm_q | (24'(bus.load_data_i) << {byte_cnt_q, 3'b000});
      end
    end else if (bus.reload_i) begin
      state_d    = ST_LOAD;
      word_ptr_d = '0;
      byte_cnt_d = 2'd0;
      asm_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BOOT_LOAD ? ST_LOAD : ST_READY;
      word_ptr_q  <= '0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= '0;
      load_done_q <= 1'b0;
      use_ram_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_ptr_q  <= word_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      load_done_q <= load_done_d;
      use_ram_q   <= use_ram_d;
      fault_q     <= fault_d;
    end
  end

  // Array contents are never reset so the store maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[word_ptr_q] <= wr_data;
    end
    if (bus.imem_en_i && !fetch_fault) begin
      ram_rdata_q <= mem[fetch_idx[AW-1:0]];
    end
  end

  assign bus.imem_rdata_o = use_ram_q ? ram_rdata_q : NOP_INSN;
  assign bus.imem_fault_o = fault_q;
  assign bus.load_ready_o = (state_q == ST_LOAD);
  assign bus.busy_o       = (state_q == ST_LOAD);
  assign bus.load_done_o  = load_done_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder against a byte-queue memory model.
module tb_imem_responder;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if bus();

  imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .BOOT_LOAD  (1'b1),
    .NOP_INSN   (NOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit          m_load;
  int          m_ptr;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_mem[DEPTH];
  logic [31:0] m_rdata;
  bit          m_fault;
  bit          m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit en, input logic [31:0] addr, input bit v,
                       input logic [7:0] d, input bit last, input bit rl);
    bus.imem_en_i    = en;
    bus.imem_addr_i  = addr;
    bus.load_valid_i = v;
    bus.load_data_i  = d;
    bus.load_last_i  = last;
    bus.reload_i     = rl;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 8)
      0:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
      2:       return BASE - 32'(4 * $urandom_range(1, 8));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  // Reference: bytes collect in a queue; a full or final word is packed little-endian.
  function automatic void model_step();
    logic [31:0] idx;
    logic [31:0] w;
    bit          f;
    if (rst) begin
      m_rdata = NOP;
      m_fault = 1'b0;
      m_done  = 1'b0;
      m_load  = 1'b1;
      m_ptr   = 0;
      m_bytes.delete();
      return;
    end
    if (bus.imem_en_i) begin
      if (m_load) begin
        m_rdata = NOP;
        m_fault = 1'b0;
      end else begin
        idx = (bus.imem_addr_i - BASE) / 4;
        f   = (bus.imem_addr_i % 4 != 0) || (idx >= DEPTH);
        m_fault = f;
        m_rdata = f ? NOP : m_mem[int'(idx)];
      end
    end
    m_done = 1'b0;
    if (m_load) begin
      if (bus.load_valid_i) begin
        m_bytes.push_back(bus.load_data_i);
        if (bus.load_last_i || m_bytes.size() == 4) begin
          w = 32'h0;
          foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
          m_mem[m_ptr] = w;
          m_ptr++;
          m_bytes.delete();
          if (bus.load_last_i || m_ptr == DEPTH) begin
            m_load = 1'b0;
            m_ptr  = 0;
            m_done = 1'b1;
          end
        end
      end
    end else if (bus.reload_i) begin
      m_load = 1'b1;
      m_ptr  = 0;
      m_bytes.delete();
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("rdata", bus.imem_rdata_o, m_rdata);
    check("fault", 32'(bus.imem_fault_o), 32'(m_fault));
    check("done", 32'(bus.load_done_o), 32'(m_done));
    check("busy", 32'(bus.busy_o), 32'(m_load));
    check("ready", 32'(bus.load_ready_o), 32'(m_load));
  endtask

  logic [7:0] img1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] img2 [3] = '{8'hAA, 8'hBB, 8'hCC};
  logic [7:0] img3 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1;
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cycle();
    check("rst_rdata_nop", bus.imem_rdata_o, NOP);
    check("rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b0;

    // Two-word boot image.
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom), rand_addr(), 1'b1, img1[i], i == 7, 1'b0);
      cycle();
    end
    check("img1_done_pulse", 32'(bus.load_done_o), 32'd1);
    check("img1_busy_fell", 32'(bus.busy_o), 32'd0);
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("img1_done_one_cycle", 32'(bus.load_done_o), 32'd0);

    // Fetch word 1, then stall with the address wandering.
    drive(1'b1, BASE + 32'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("fetch_w1", bus.imem_rdata_o, 32'h0010_0093);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, rand_addr(), 1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle();
      check("stall_hold", bus.imem_rdata_o, 32'h0010_0093);
    end
    drive(1'b1, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("fetch_w0", bus.imem_rdata_o, 32'h0000_0013);

    // Fault cases: misaligned, one past the end, below base.
    drive(1'b1, BASE + 32'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("misalign_fault", 32'(bus.imem_fault_o), 32'd1);
    check("misalign_nop", bus.imem_rdata_o, NOP);
    drive(1'b1, BASE + 32'(4 * DEPTH), 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("range_fault", 32'(bus.imem_fault_o), 32'd1);
    drive(1'b1, BASE - 32'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("below_base_fault", 32'(bus.imem_fault_o), 32'd1);

    // Short final word: three bytes, upper byte zero-filled.
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, BASE, 1'b1, img2[i], i == 2, 1'b0);
      cycle();
    end
    drive(1'b1, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("partial_word", bus.imem_rdata_o, 32'h00CC_BBAA);

    // Overlong stream with no last flag: LOAD must stop at the final word.
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      drive(1'($urandom), rand_addr(), 1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle();
    end
    check("overrun_ready_low", 32'(bus.load_ready_o), 32'd0);
    drive(1'b1, BASE + 32'(4 * (DEPTH - 1)), 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();

    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom), rand_addr(), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
      cycle();
    end

    // Reset mid-load, then a fresh image; reload while in LOAD is ignored.
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, BASE, 1'b1, 8'hEE, 1'b0, 1'b0);
      cycle();
    end
    rst = 1'b1;
    drive(1'b0, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, BASE, 1'b1, img3[i], i == 3, i == 0);
      cycle();
    end
    drive(1'b1, BASE, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    check("after_reset_image", bus.imem_rdata_o, 32'h4433_2211);
    drive(1'b1, BASE + 32'd4, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    check("reload_busy", 32'(bus.busy_o), 32'd1);

    // Mixed random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), rand_addr(), 1'($urandom), 8'($urandom),
            ($urandom % 8) == 0, ($urandom % 16) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
